// File: rtl/dec_scan_n.sv
// rtl/dec_scan_n.sv - registered N-to-2^N one-hot decoder with enable-gated auto-scan sequencer
module dec_scan_n #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_L,
    input  logic                 E1,
    input  logic                 E0_L,
    input  logic                 MODE,
    input  logic                 LOAD,
    input  logic                 STOP,
    input  logic [N-1:0]         X,
    input  logic [DWELL_W-1:0]   DWELL,
    output logic [(1<<N)-1:0]    Y,
    output logic [N-1:0]         IDX,
    output logic                 SCANNING,
    output logic                 WRAP
);

    localparam int LINES = 1 << N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [N-1:0]         idx_n;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;
    logic [LINES-1:0]     y_n;
    logic                 wrap_n;
    logic                 scanning_n;
    logic                 en;

    assign en = E1 & ~E0_L;

    always_comb begin
        state_n    = state;
        idx_n      = IDX;
        cnt_n      = cnt;
        dwell_n    = dwell_q;
        wrap_n     = 1'b0;
        if (STOP) begin
            state_n = ST_IDLE;
        end else if (LOAD) begin
            idx_n = X;
            if (MODE) begin
                dwell_n = DWELL;
                cnt_n   = DWELL;
                state_n = ST_SCAN;
            end else begin
                state_n = ST_DIRECT;
            end
        end else if (state == ST_SCAN && en) begin
            // Counter reaching zero ends the dwell of the current line.
            if (cnt != '0) begin
                cnt_n = cnt - DWELL_W'(1);
            end else begin
                idx_n  = IDX + N'(1);
                cnt_n  = dwell_q;
                wrap_n = (IDX == {N{1'b1}});
            end
        end
        scanning_n = (state_n == ST_SCAN);
        // Outputs are precomputed from next state so Y lines up with IDX after the edge.
        y_n = '0;
        if (en && state_n != ST_IDLE) begin
            y_n = LINES'(1) << idx_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state    <= ST_IDLE;
            IDX      <= '0;
            cnt      <= '0;
            dwell_q  <= '0;
            Y        <= '0;
            SCANNING <= 1'b0;
            WRAP     <= 1'b0;
        end else begin
            state    <= state_n;
            IDX      <= idx_n;
            cnt      <= cnt_n;
            dwell_q  <= dwell_n;
            Y        <= y_n;
            SCANNING <= scanning_n;
            WRAP     <= wrap_n;
        end
    end

endmodule
